delay_sum_accumulator: RTL and testbench
========================================

// Module: delay_sum_accumulator
// PURPOSE
//  Downstream of the delay beamformer sample selector. Consumes its
//  output_value/data_good stream and sums NUM_CH time-aligned channel samples
//  into one beam point. Emits one beam point per group and counts points
//  within a frame. Feeds the beam output buffer.
// PARAMETERS
//  DATA_W      16    width of incoming signed (two's complement) sample
//  NUM_CH      8     good samples summed per beam point; power of 2, >=2
//  NUM_POINTS  1024  beam points per frame; point counter wraps here
//  ACC_W       DATA_W+$clog2(NUM_CH)  accumulator/output width (no overflow)
// PORTS
//  clk           in   1       system clock, all logic on rising edge
//  rst_n         in   1       asynchronous active-low reset
//  run           in   1       1=accept samples; 0=ignore sample_good
//  flush         in   1       sync: drop partial sum, restart point count
//  sample_value  in   DATA_W  signed sample (delay beamformer output_value)
//  sample_good   in   1       sample valid (delay beamformer data_good)
//  beam_sum      out  ACC_W   signed beam point result
//  beam_valid    out  1       1-cycle pulse: beam_sum is new
//  point_index   out  $clog2(NUM_POINTS)  index of point on beam_sum
//  frame_done    out  1       1-cycle pulse with beam_valid of last point
//  busy          out  1       1 when partial sum held (ch_cnt != 0)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, acc=0, ch_cnt=0, pt_cnt=0,
//    beam_sum=0, beam_valid=0, point_index=0, frame_done=0, busy=0.
//  - FSM: IDLE -> ACCUM when run=1; ACCUM -> IDLE when run=0 and ch_cnt=0;
//    run=0 mid-group: stay ACCUM holding partial sum, no accept until run=1.
//  - Accept = state ACCUM & run & sample_good & !flush. On accept: sample
//    sign-extended to ACC_W, added to acc; ch_cnt increments.
//  - On accept with ch_cnt=NUM_CH-1: next cycle beam_sum=acc+sample,
//    beam_valid=1, point_index=pt_cnt; acc<=0, ch_cnt<=0 same edge, so the
//    next group may accept in the very next cycle (no bubble, full rate).
//  - Latency: 1 clk from last accepted sample to beam_valid.
//  - pt_cnt increments per emitted point; at NUM_POINTS-1 frame_done pulses
//    with beam_valid and pt_cnt wraps to 0.
//  - beam_sum/point_index hold last value between beam_valid pulses.
//  - flush (any state): acc=0, ch_cnt=0, pt_cnt=0 next edge; flush wins
//    over simultaneous sample_good (sample discarded, no beam_valid). A
//    beam_valid already registered still pulses that cycle.
//  - Arithmetic: signed, ACC_W sized so NUM_CH full-scale samples never
//    overflow; no saturation logic needed.
//  - beam_valid/frame_done never asserted while rst_n=0; reset mid-group
//    discards partial sum.
// CONFIGURATION
//  BEAM_AVG_EN defined: beam_sum = (acc+sample) >>> $clog2(NUM_CH),
//    arithmetic shift (floor toward -inf), sign-extended to ACC_W. Same
//    latency. Undefined: beam_sum is raw sum.
// TESTING (NUM_CH=8, NUM_POINTS=4, DATA_W=16 unless noted)
//  1 reset: rst_n low mid-group -> all outputs 0 immediately, busy=0.
//  2 run=1, 8 consecutive good samples value 100 -> beam_sum=800,
//    beam_valid 1 clk after 8th, point_index=0; 16 back-to-back -> two
//    pulses 8 clks apart, second point_index=1.
//  3 samples -32768 x8 -> beam_sum=-262144 (no wrap); with BEAM_AVG_EN
//    samples {-3,0,0,0,0,0,0,0} -> beam_sum=-1.
//  4 good gapped with sample_good=0 cycles, and run dropped after 3
//    samples then restored -> sum correct, busy=1 throughout gap.
//  5 4 groups emitted -> point_index 0..3, frame_done with 4th, 5th is 0.
//  6 flush coincident with 5th sample of group -> no beam_valid; next
//    8 samples of 10 -> beam_sum=80, point_index=0.

Source files
------------

// File: rtl/delay_sum_accumulator.sv
// -----------------------------------------------------------------------------
// delay_sum_accumulator
//
// Purpose
//   Sits behind the delay beamformer sample selector. It adds NUM_CH
//   time-aligned channel samples into one beam point. It emits one point per
//   group of NUM_CH accepted samples, and it numbers the points within a frame
//   of NUM_POINTS. The output feeds the beam output buffer.
//
// Parameters
//   DATA_W      width of the incoming signed sample
//   NUM_CH      samples summed per beam point (power of 2, >= 2)
//   NUM_POINTS  beam points per frame (>= 2); the point counter wraps here
//   ACC_W       accumulator / beam_sum width, sized so a full group of
//               full-scale samples cannot overflow
//
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   run           in   1 = accept samples, 0 = ignore sample_good
//   flush         in   synchronous: drop the partial sum, restart point count
//   sample_value  in   signed sample (beamformer output_value)
//   sample_good   in   sample valid (beamformer data_good)
//   beam_sum      out  signed beam point, held between beam_valid pulses
//   beam_valid    out  1-cycle pulse, beam_sum/point_index are new
//   point_index   out  index of the point on beam_sum within the frame
//   frame_done    out  1-cycle pulse with beam_valid of the frame's last point
//   busy          out  a partial sum is held (channel count != 0)
//
// Configuration
//   BEAM_AVG_EN   when defined, beam_sum is the group mean: the raw sum is
//                 arithmetically shifted right by log2(NUM_CH), which rounds
//                 toward minus infinity. Latency is unchanged. When the macro
//                 is undefined, beam_sum is the raw sum.
// -----------------------------------------------------------------------------
module delay_sum_accumulator #(
   parameter int DATA_W     = 16,
   parameter int NUM_CH     = 8,
   parameter int NUM_POINTS = 1024,
   parameter int ACC_W      = DATA_W + $clog2(NUM_CH)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          run,
   input  logic                          flush,
   input  logic signed [DATA_W-1:0]      sample_value,
   input  logic                          sample_good,
   output logic signed [ACC_W-1:0]       beam_sum,
   output logic                          beam_valid,
   output logic [$clog2(NUM_POINTS)-1:0] point_index,
   output logic                          frame_done,
   output logic                          busy
);

   localparam int CH_W = $clog2(NUM_CH);
   localparam int PT_W = $clog2(NUM_POINTS);

   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
   localparam logic [PT_W-1:0] LAST_PT = PT_W'(NUM_POINTS - 1);

   // Two-state controller. ST_ACCUM is also held while run is low if a
   // partial group is still pending. This lets the group resume exactly
   // where it stopped.
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ACCUM = 1'b1;

   logic [0:0]              state;
   logic [0:0]              state_nxt;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] sample_ext;
   logic signed [ACC_W-1:0] sum_nxt;
   logic signed [ACC_W-1:0] result_nxt;
   logic [CH_W-1:0]         ch_cnt;
   logic [PT_W-1:0]         pt_cnt;
   logic                    accept;
   logic                    last_ch;
   logic                    last_pt;
   logic                    emit;

   // ---------------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------------
   // Flush takes priority over a coincident sample. The sample is discarded.
   assign accept  = (state == ST_ACCUM) && run && sample_good && !flush;
   assign last_ch = (ch_cnt == LAST_CH);
   assign last_pt = (pt_cnt == LAST_PT);
   assign emit    = accept && last_ch;

   assign sample_ext = {{(ACC_W - DATA_W){sample_value[DATA_W-1]}}, sample_value};
   assign sum_nxt    = acc + sample_ext;

`ifdef BEAM_AVG_EN
   // The arithmetic shift on a signed operand floors toward minus infinity.
   // The upper bits come out as copies of the sign bit.
   assign result_nxt = sum_nxt >>> CH_W;
`else
   assign result_nxt = sum_nxt;
`endif

   assign busy = (ch_cnt != '0);

   // ---------------------------------------------------------------------------
   // Controller
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: assign a default before the case so that every path drives
      // state_nxt. A path that leaves it unassigned would infer a latch.
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (run) state_nxt = ST_ACCUM;
         end
         ST_ACCUM: begin
            // Leave only when no partial group is held. With run low and a
            // partial group present, the partial sum waits here for run.
            if (!run && (ch_cnt == '0)) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Accumulator, channel counter, point counter
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         acc    <= '0;
         ch_cnt <= '0;
         pt_cnt <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment. Every
         // register then samples pre-edge values, whatever order the
         // statements are in.
         state <= state_nxt;
         if (flush) begin
            acc    <= '0;
            ch_cnt <= '0;
            pt_cnt <= '0;
         end else if (accept) begin
            if (last_ch) begin
               // Clearing on the same edge that completes the group lets the
               // next group start accepting in the very next cycle.
               acc    <= '0;
               ch_cnt <= '0;
               pt_cnt <= last_pt ? '0 : pt_cnt + PT_W'(1);
            end else begin
               acc    <= sum_nxt;
               ch_cnt <= ch_cnt + CH_W'(1);
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Output registers: one cycle from the last accepted sample to beam_valid
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beam_sum    <= '0;
         beam_valid  <= 1'b0;
         point_index <= '0;
         frame_done  <= 1'b0;
      end else begin
         beam_valid <= emit;
         frame_done <= emit && last_pt;
         // beam_sum and point_index hold their value between pulses.
         if (emit) begin
            beam_sum    <= result_nxt;
            point_index <= pt_cnt;
         end
      end
   end

endmodule

// File: tb/tb_delay_sum_accumulator.sv
module tb_delay_sum_accumulator;

   localparam int DATA_W     = 16;
   localparam int NUM_CH     = 8;
   localparam int NUM_POINTS = 4;
   localparam int ACC_W      = DATA_W + $clog2(NUM_CH);
   localparam int PT_W       = $clog2(NUM_POINTS);

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     run = 1'b0;
   logic                     flush = 1'b0;
   logic signed [DATA_W-1:0] sample_value = '0;
   logic                     sample_good = 1'b0;
   logic signed [ACC_W-1:0]  beam_sum;
   logic                     beam_valid;
   logic [PT_W-1:0]          point_index;
   logic                     frame_done;
   logic                     busy;

   delay_sum_accumulator #(
      .DATA_W(DATA_W), .NUM_CH(NUM_CH), .NUM_POINTS(NUM_POINTS), .ACC_W(ACC_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .flush(flush),
      .sample_value(sample_value), .sample_good(sample_good),
      .beam_sum(beam_sum), .beam_valid(beam_valid), .point_index(point_index),
      .frame_done(frame_done), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: the partial group is a list of accepted samples. A
   // point is the sum (or floor mean) of a completed list of NUM_CH samples.
   // ---------------------------------------------------------------------------
   typedef struct {
      longint sum;
      int     idx;
      bit     frame;
      int     cyc;
   } exp_t;

   exp_t sb[$];
   int   m_part[$];
   int   m_pt = 0;
   bit   m_active = 1'b0;

   function automatic longint floor_div(input longint s, input longint d);
      if (s >= 0) return s / d;
      return -((-s + d - 1) / d);
   endfunction

   // Applies the rules for one clock edge, given the inputs present before it.
   task automatic model_step(input bit r, input bit f, input bit g, input int v);
      int     pre;
      bit     acc_ok;
      longint s;
      exp_t   e;
      pre    = m_part.size();
      acc_ok = m_active && r && g && !f;
      if (f) begin
         m_part.delete();
         m_pt = 0;
      end else if (acc_ok) begin
         m_part.push_back(v);
         if (m_part.size() == NUM_CH) begin
            s = 0;
            foreach (m_part[i]) s += m_part[i];
`ifdef BEAM_AVG_EN
            e.sum = floor_div(s, NUM_CH);
`else
            e.sum = s;
`endif
            e.idx   = m_pt;
            e.frame = (m_pt == NUM_POINTS - 1);
            e.cyc   = cyc + 1;
            sb.push_back(e);
            m_pt = (m_pt + 1) % NUM_POINTS;
            m_part.delete();
         end
      end
      if (!m_active) m_active = r;
      else if (!r && pre == 0) m_active = 1'b0;
   endtask

   task automatic drive(input bit r, input bit f, input bit g, input int v);
      run          = r;
      flush        = f;
      sample_good  = g;
      sample_value = DATA_W'(v);
      model_step(r, f, g, v);
      @(posedge clk);
      #1;
      check("busy", busy, m_part.size() != 0);
   endtask

   // ---------------------------------------------------------------------------
   // Monitor: pops an expectation whenever the DUT presents a beam point
   // ---------------------------------------------------------------------------
   longint last_sum = 0;
   int     last_idx = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_beam_valid", beam_valid, 0);
         check("rst_frame_done", frame_done, 0);
         check("rst_beam_sum", beam_sum, 0);
         check("rst_point_index", point_index, 0);
         last_sum = 0;
         last_idx = 0;
      end else begin
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            n_checks++;
            n_errors++;
            $display("FAIL missed_beam: got no beam_valid, expected sum %0d at cycle %0d",
                     sb[0].sum, sb[0].cyc);
            void'(sb.pop_front());
         end
         if (beam_valid) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_beam: got beam_valid sum %0d, expected none at cycle %0d",
                        beam_sum, cyc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("beam_sum", beam_sum, e.sum);
               check("point_index", point_index, e.idx);
               check("frame_done", frame_done, e.frame);
               check("latency_cycle", cyc, e.cyc);
               last_sum = e.sum;
               last_idx = e.idx;
            end
         end else begin
            check("frame_done_idle", frame_done, 0);
            check("beam_sum_hold", beam_sum, last_sum);
            check("point_index_hold", point_index, last_idx);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int gap_vals[8];
      gap_vals = '{5, -7, 1000, -2000, 3, 32767, -32768, 11};

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Basic group of 8 x 100, then 16 back-to-back from a fresh start.
      drive(1, 0, 0, 0);
      for (int i = 0; i < 8; i++) drive(1, 0, 1, 100);
      drive(1, 1, 0, 0);
      for (int i = 0; i < 16; i++) drive(1, 0, 1, 100);
      drive(1, 0, 0, 0);

      // Full-scale negative group and the floor-rounding corner.
      drive(1, 1, 0, 0);
      for (int i = 0; i < 8; i++) drive(1, 0, 1, -32768);
      for (int i = 0; i < 8; i++) drive(1, 0, 1, (i == 0) ? -3 : 0);
      drive(1, 0, 0, 0);

      // Gapped samples, with run dropped after 3 samples and then restored.
      drive(1, 1, 0, 0);
      for (int i = 0; i < 8; i++) begin
         drive(1, 0, 1, gap_vals[i]);
         if (i == 2) repeat (3) drive(0, 0, 1, 999);
         else if (i % 2 == 1) drive(1, 0, 0, 0);
      end
      drive(1, 0, 0, 0);

      // Five groups: points 0..3, frame_done on the 4th, then the count wraps.
      drive(1, 1, 0, 0);
      for (int g = 0; g < 5; g++)
         for (int i = 0; i < 8; i++) drive(1, 0, 1, $signed(16'($urandom)));
      drive(1, 0, 0, 0);

      // A flush that coincides with the 5th sample discards the group.
      drive(1, 1, 0, 0);
      for (int i = 0; i < 4; i++) drive(1, 0, 1, 50);
      drive(1, 1, 1, 50);
      for (int i = 0; i < 8; i++) drive(1, 0, 1, 10);
      drive(1, 0, 0, 0);

      // Asynchronous reset mid-group: outputs clear immediately.
      for (int i = 0; i < 3; i++) drive(1, 0, 1, 77);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_beam_sum", beam_sum, 0);
      check("async_rst_point_index", point_index, 0);
      check("async_rst_beam_valid", beam_valid, 0);
      check("async_rst_frame_done", frame_done, 0);
      check("async_rst_busy", busy, 0);
      m_part.delete();
      m_pt = 0;
      m_active = 1'b0;
      run = 1'b0;
      sample_good = 1'b0;
      flush = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         bit r, f, g;
         r = ($urandom_range(0, 9) != 0);
         f = ($urandom_range(0, 49) == 0);
         g = ($urandom_range(0, 9) < 7);
         drive(r, f, g, $signed(16'($urandom)));
      end

      repeat (3) drive(1, 0, 0, 0);
      if (sb.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard_drain: got %0d pending points, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
